env_osc_voice: RTL and testbench
================================

// Module: env_osc_voice
// PURPOSE
//   Single synth voice core: 32-bit DDS phase accumulator (sawtooth oscillator) plus a 32-bit ADSR envelope.
//   The envelope takes 7-bit attack/decay/release controls through an exponential rate table and a 7-bit sustain level.
//   Sits between the MIDI note/controller registers (gate, phase increment, CC values) and the VCA/DAC stages.
// PARAMETERS
//   none (all widths fixed: phase 32, envelope 32, controls 7, internal rate 14)
// PORTS
//   clk        in   1   system clock; single clock domain
//   rst        in   1   asynchronous, active-high reset
//   gate       in   1   note gate; 1 = key held
//   phase_inc  in   32  DDS phase increment per clock
//   attack     in   7   attack rate control (0 = slowest, 127 = fastest)
//   decay      in   7   decay rate control
//   sustain    in   7   sustain level control
//   release    in   7   release rate control
//   osc_out    out  32  phase accumulator value (sawtooth)
//   env_out    out  32  envelope level (0 .. 0xFFFFFFFF)
//   env_state  out  3   0 IDLE, 1 ATTACK, 2 DECAY, 3 SUSTAIN, 4 RELEASE
// BEHAVIOUR
//   Reset: osc_out=0, env_out=0, env_state=IDLE, sustain level reg=0, all rate regs=64.
//   DDS: every clk, acc <= acc + phase_inc, mod 2^32 with natural wrap; osc_out = acc.
//   Rate table (lin2exp): rate14 = {1'b1, c[3:0]} << (c[6:4] + 2).
//     c=0 gives 64; c=127 gives 15872; monotonic in c.
//     A, D and R rates are registered each clk, so the rate table has 1-cycle latency.
//   Sustain level: S = {sustain, 25'b0}, registered each clk (1-cycle latency).
//   Each edge: state and env update in the same edge, both computed from the current (registered) state and current gate.
//   IDLE: env held at 0. gate=1 -> ATTACK; env does not move on this edge.
//   ATTACK:
//     gate=0 -> RELEASE, env unchanged this edge.
//     Else if env + A (33-bit compare) >= 0xFFFFFFFF: env = 0xFFFFFFFF, state -> DECAY.
//     Else env += A.
//   DECAY:
//     gate=0 -> RELEASE.
//     Else if env <= S or env - D <= S (no underflow): env = S, state -> SUSTAIN.
//     Else env -= D.
//   SUSTAIN:
//     gate=0 -> RELEASE.
//     Else env = S; env tracks sustain changes with 1-cycle latency.
//   RELEASE:
//     gate=1 -> ATTACK, starting from the current env (no reset to 0).
//     Else if env <= R: env = 0, state -> IDLE.
//     Else env -= R.
//   env_out never wraps; it always saturates at 0 and 0xFFFFFFFF.
//   Gate is sampled synchronously. A gate pulse of 1 clk starts ATTACK, and the following low gate moves to RELEASE one edge later.
//   Rate or sustain changes mid-phase take effect 1 cycle later, with no state change.
//   Reset asserted mid-operation: all outputs return to reset values immediately (async).
//   sustain=0 gives S=0; DECAY clamps to 0 and stays in SUSTAIN at 0 until gate falls.
// TESTING
//   1. Reset, then idle with gate=0 and phase_inc=0 -> osc_out=0, env_out=0, env_state=0 for all cycles.
//   2. phase_inc=0x40000000 -> osc_out 0x40000000, 0x80000000, 0xC0000000, 0x00000000 on successive edges (wrap).
//   3. attack=127, raise gate -> env_state=1 after 1 edge, env_out=N*15872 after N more edges.
//      Reaches 0xFFFFFFFF on the 270601st increment; env_state then = 2.
//   4. Continuing 3 with decay=127, sustain=64 -> env decreases by 15872 per clk.
//      It clamps to exactly 0x80000000 and env_state=3; changing sustain to 32 -> env_out=0x40000000 one cycle later.
//   5. Drop gate in SUSTAIN (release=0, R=64) -> state 4, env decreases 64/clk, ends at exactly 0 and state 0.
//   6. Re-raise gate mid-release at env=E -> state 1 and env climbs from E (not 0).
//      Asserting rst mid-attack -> env_out=0, state 0, osc_out=0 immediately.

Source files
------------

// File: rtl/env_osc_voice.sv
// Synth voice core: 32-bit DDS sawtooth accumulator plus a saturating ADSR envelope.
// Rates and sustain level are registered from the 7-bit controls, so control changes act one cycle later.
module env_osc_voice (
  input  logic        clk,
  input  logic        rst,
  input  logic        gate_i,
  input  logic [31:0] phase_inc_i,
  input  logic [6:0]  attack_i,
  input  logic [6:0]  decay_i,
  input  logic [6:0]  sustain_i,
  input  logic [6:0]  release_i,
  output logic [31:0] osc_out_o,
  output logic [31:0] env_out_o,
  output logic [2:0]  env_state_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } env_state_e;

  localparam logic [13:0] RATE_RESET = 14'd64;
  localparam logic [31:0] ENV_MAX    = 32'hFFFF_FFFF;

  // Exponential rate curve: 4-bit mantissa with an implicit leading one, 3-bit octave.
  function automatic logic [13:0] lin2exp(input logic [6:0] c);
    logic [13:0] mant;
    mant = {9'd0, 1'b1, c[3:0]};
    return mant << ({1'b0, c[6:4]} + 4'd2);
  endfunction

  logic [31:0] acc_q, acc_d;
  logic [13:0] a_rate_q, d_rate_q, r_rate_q;
  logic [31:0] s_lvl_q;
  logic [31:0] env_q;
  env_state_e  state_q;

  logic [32:0] att_sum;
  logic [32:0] dec_floor;
  logic        att_full;
  logic        dec_done;
  logic        rel_done;

  assign acc_d     = acc_q + phase_inc_i;
  assign att_sum   = {1'b0, env_q} + {19'd0, a_rate_q};
  assign dec_floor = {1'b0, s_lvl_q} + {19'd0, d_rate_q};
  assign att_full  = (att_sum >= {1'b0, ENV_MAX});
  // env - D <= S, evaluated without underflow.
  assign dec_done  = ({1'b0, env_q} <= dec_floor);
  assign rel_done  = (env_q <= {18'd0, r_rate_q});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      a_rate_q <= RATE_RESET;
      d_rate_q <= RATE_RESET;
      r_rate_q <= RATE_RESET;
      s_lvl_q  <= '0;
      env_q    <= '0;
      state_q  <= S_IDLE;
    end else begin
      acc_q    <= acc_d;
      a_rate_q <= lin2exp(attack_i);
      d_rate_q <= lin2exp(decay_i);
      r_rate_q <= lin2exp(release_i);
      s_lvl_q  <= {sustain_i, 25'd0};

      case (state_q)
        S_IDLE: begin
          env_q <= '0;
          if (gate_i) state_q <= S_ATTACK;
        end
        S_ATTACK: begin
          if (!gate_i) begin
            state_q <= S_RELEASE;
          end else if (att_full) begin
            env_q   <= ENV_MAX;
            state_q <= S_DECAY;
          end else begin
            env_q <= att_sum[31:0];
          end
        end
        S_DECAY: begin
          if (!gate_i) begin
            state_q <= S_RELEASE;
          end else if (dec_done) begin
            env_q   <= s_lvl_q;
            state_q <= S_SUSTAIN;
          end else begin
            env_q <= env_q - {18'd0, d_rate_q};
          end
        end
        S_SUSTAIN: begin
          if (!gate_i) state_q <= S_RELEASE;
          else         env_q   <= s_lvl_q;
        end
        S_RELEASE: begin
          if (gate_i) begin
            state_q <= S_ATTACK;
          end else if (rel_done) begin
            env_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            env_q <= env_q - {18'd0, r_rate_q};
          end
        end
        default: begin
          env_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign osc_out_o   = acc_q;
  assign env_out_o   = env_q;
  assign env_state_o = state_q;

endmodule

// File: tb/tb_env_osc_voice.sv
// Bench for env_osc_voice: randomized and directed scenarios checked against an arithmetic
// model of the oscillator and ADSR envelope kept in plain 64-bit integers.
module tb_env_osc_voice;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        gate = 1'b0;
  logic [31:0] phase_inc = '0;
  logic [6:0]  attack = '0;
  logic [6:0]  decay = '0;
  logic [6:0]  sustain = '0;
  logic [6:0]  rel = '0;
  logic [31:0] osc_out;
  logic [31:0] env_out;
  logic [2:0]  env_state;

  int n_pass  = 0;
  int n_total = 0;

  localparam longint ENV_MAX = 64'h0000_0000_FFFF_FFFF;

  // Model state: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
  longint m_env, m_osc, m_A, m_D, m_R, m_S;
  int     m_state;

  env_osc_voice dut (
    .clk         (clk),
    .rst         (rst),
    .gate_i      (gate),
    .phase_inc_i (phase_inc),
    .attack_i    (attack),
    .decay_i     (decay),
    .sustain_i   (sustain),
    .release_i   (rel),
    .osc_out_o   (osc_out),
    .env_out_o   (env_out),
    .env_state_o (env_state)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic longint rate_of(input int c);
    return longint'(16 + c % 16) * longint'(4 << (c / 16));
  endfunction

  task automatic model_reset();
    m_env = 0; m_osc = 0; m_state = 0;
    m_A = 64; m_D = 64; m_R = 64; m_S = 0;
  endtask

  task automatic model_edge();
    case (m_state)
      0: if (gate) m_state = 1;
      1: begin
        if (!gate) m_state = 4;
        else if (m_env + m_A >= ENV_MAX) begin m_env = ENV_MAX; m_state = 2; end
        else m_env = m_env + m_A;
      end
      2: begin
        if (!gate) m_state = 4;
        else if (m_env <= m_S || m_env - m_D <= m_S) begin m_env = m_S; m_state = 3; end
        else m_env = m_env - m_D;
      end
      3: begin
        if (!gate) m_state = 4;
        else m_env = m_S;
      end
      default: begin
        if (gate) m_state = 1;
        else if (m_env <= m_R) begin m_env = 0; m_state = 0; end
        else m_env = m_env - m_R;
      end
    endcase
    m_osc = (m_osc + longint'(phase_inc)) % (ENV_MAX + 1);
    m_A = rate_of(int'(attack));
    m_D = rate_of(int'(decay));
    m_R = rate_of(int'(rel));
    m_S = longint'(sustain) * 33554432;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    gate = 0; phase_inc = '0;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (osc_out !== 32'd0 || env_out !== 32'd0 || env_state !== 3'd0)
      $display("FAIL reset_async: osc=%h env=%h state=%0d, expected 0/0/0", osc_out, env_out, env_state);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++;
      if (osc_out !== 32'd0 || env_out !== 32'd0 || env_state !== 3'd0)
        $display("FAIL reset_idle cyc %0d: osc=%h env=%h state=%0d, expected 0/0/0", i, osc_out, env_out, env_state);
      else n_pass++;
    end
  endtask

  task automatic test_dds_wrap();
    logic [31:0] exp_osc [4];
    exp_osc[0] = 32'h4000_0000; exp_osc[1] = 32'h8000_0000;
    exp_osc[2] = 32'hC000_0000; exp_osc[3] = 32'h0000_0000;
    do_reset();
    phase_inc = 32'h4000_0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (osc_out !== exp_osc[i])
        $display("FAIL dds_wrap step %0d: osc=%h, expected %h", i, osc_out, exp_osc[i]);
      else n_pass++;
    end
  endtask

  task automatic test_gate_pulse();
    logic [2:0] exp_st [3];
    exp_st[0] = 3'd1; exp_st[1] = 3'd4; exp_st[2] = 3'd0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      gate = (i == 0);
      tick();
      n_total++;
      if (env_state !== exp_st[i] || env_out !== 32'd0)
        $display("FAIL gate_pulse step %0d: state=%0d env=%h, expected state=%0d env=0", i, env_state, env_out, exp_st[i]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit bad;
    int len;
    bad = 0;
    do_reset();
    for (int seg = 0; seg < 24 && !bad; seg++) begin
      gate      = (seg % 2 == 0);
      attack    = 7'($urandom_range(0, 127));
      decay     = 7'($urandom_range(0, 127));
      sustain   = 7'($urandom_range(0, 127));
      rel       = 7'($urandom_range(0, 127));
      phase_inc = $urandom;
      len = (seg % 5 == 4) ? 1 : int'($urandom_range(2, 250));
      for (int k = 0; k < len && !bad; k++) begin
        if ($urandom_range(0, 19) == 0) sustain = 7'($urandom_range(0, 127));
        if ($urandom_range(0, 29) == 0) rel = 7'($urandom_range(0, 127));
        tick();
        n_total++;
        if (osc_out !== m_osc[31:0] || env_out !== m_env[31:0] || env_state !== 3'(m_state)) begin
          $display("FAIL random seg %0d cyc %0d: osc=%h env=%h state=%0d, expected osc=%h env=%h state=%0d",
                   seg, k, osc_out, env_out, env_state, m_osc[31:0], m_env[31:0], m_state);
          bad = 1;
        end else n_pass++;
      end
    end
  endtask

  task automatic test_full_envelope();
    bit bad;
    int n;
    bad = 0;
    do_reset();
    attack = 7'd127; decay = 7'd127; sustain = 7'd127; rel = 7'd127;
    phase_inc = $urandom;
    gate = 1;
    tick();
    n_total++;
    if (env_state !== 3'd1 || env_out !== 32'd0)
      $display("FAIL attack_start: state=%0d env=%h, expected state=1 env=0", env_state, env_out);
    else n_pass++;

    n = 0;
    while (env_state == 3'd1 && n < 300000 && !bad) begin
      tick(); n++;
      n_total++;
      if (osc_out !== m_osc[31:0] || env_out !== m_env[31:0] || env_state !== 3'(m_state)) begin
        $display("FAIL attack_ramp cyc %0d: osc=%h env=%h state=%0d, expected osc=%h env=%h state=%0d",
                 n, osc_out, env_out, env_state, m_osc[31:0], m_env[31:0], m_state);
        bad = 1;
      end else n_pass++;
      if (n == 1000) begin
        n_total++;
        if (env_out !== 32'd15872000) $display("FAIL attack_1000: env=%0d, expected 15872000", env_out);
        else n_pass++;
      end
    end
    n_total++;
    if (n != 270601 || env_out !== 32'hFFFF_FFFF || env_state !== 3'd2)
      $display("FAIL attack_peak: increments=%0d env=%h state=%0d, expected 270601 ffffffff 2", n, env_out, env_state);
    else n_pass++;

    n = 0;
    while (env_state == 3'd2 && n < 5000 && !bad) begin
      tick(); n++;
      n_total++;
      if (env_out !== m_env[31:0] || env_state !== 3'(m_state)) begin
        $display("FAIL decay_ramp cyc %0d: env=%h state=%0d, expected env=%h state=%0d",
                 n, env_out, env_state, m_env[31:0], m_state);
        bad = 1;
      end else n_pass++;
    end
    n_total++;
    if (n != 2115 || env_out !== 32'hFE00_0000 || env_state !== 3'd3)
      $display("FAIL decay_clamp: edges=%0d env=%h state=%0d, expected 2115 fe000000 3", n, env_out, env_state);
    else n_pass++;

    sustain = 7'd32;
    tick();
    n_total++;
    if (env_out !== 32'hFE00_0000) $display("FAIL sustain_latency: env=%h, expected fe000000", env_out);
    else n_pass++;
    tick();
    n_total++;
    if (env_out !== 32'h4000_0000 || env_state !== 3'd3)
      $display("FAIL sustain_track32: env=%h state=%0d, expected 40000000 3", env_out, env_state);
    else n_pass++;

    sustain = 7'd0;
    tick(); tick();
    n_total++;
    if (env_out !== 32'd0 || env_state !== 3'd3)
      $display("FAIL sustain_zero: env=%h state=%0d, expected 0 3", env_out, env_state);
    else n_pass++;

    sustain = 7'd1;
    tick(); tick();
    n_total++;
    if (env_out !== 32'h0200_0000 || env_state !== 3'd3)
      $display("FAIL sustain_one: env=%h state=%0d, expected 02000000 3", env_out, env_state);
    else n_pass++;

    gate = 0;
    n = 0;
    while (env_state != 3'd0 && n < 5000 && !bad) begin
      tick(); n++;
      n_total++;
      if (env_out !== m_env[31:0] || env_state !== 3'(m_state)) begin
        $display("FAIL release_ramp cyc %0d: env=%h state=%0d, expected env=%h state=%0d",
                 n, env_out, env_state, m_env[31:0], m_state);
        bad = 1;
      end else n_pass++;
    end
    n_total++;
    if (n != 2116 || env_out !== 32'd0 || env_state !== 3'd0)
      $display("FAIL release_end: edges=%0d env=%h state=%0d, expected 2116 0 0", n, env_out, env_state);
    else n_pass++;
  endtask

  task automatic test_retrigger_and_reset();
    do_reset();
    attack = 7'd90; rel = 7'd40; decay = 7'd10; sustain = 7'd50;
    phase_inc = $urandom | 32'd1;
    gate = 1;
    for (int i = 0; i < 60; i++) tick();
    gate = 0;
    for (int i = 0; i < 15; i++) tick();
    n_total++;
    if (env_out !== 32'd190976 || env_state !== 3'd4)
      $display("FAIL release_mid: env=%0d state=%0d, expected 190976 4", env_out, env_state);
    else n_pass++;

    gate = 1;
    tick();
    n_total++;
    if (env_out !== 32'd190976 || env_state !== 3'd1)
      $display("FAIL retrigger_edge: env=%0d state=%0d, expected 190976 1", env_out, env_state);
    else n_pass++;
    tick();
    n_total++;
    if (env_out !== 32'd194304 || env_state !== 3'd1 || osc_out !== m_osc[31:0])
      $display("FAIL retrigger_climb: env=%0d state=%0d osc=%h, expected 194304 1 %h",
               env_out, env_state, osc_out, m_osc[31:0]);
    else n_pass++;

    #2 rst = 1'b1;
    #1;
    n_total++;
    if (osc_out !== 32'd0 || env_out !== 32'd0 || env_state !== 3'd0)
      $display("FAIL reset_mid_attack: osc=%h env=%h state=%0d, expected 0/0/0", osc_out, env_out, env_state);
    else n_pass++;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_dds_wrap();
    test_gate_pulse();
    test_random();
    test_retrigger_and_reset();
    test_full_envelope();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
